// File: rtl/fifo_rd_arb.sv
// fifo_rd_arb: round-robin read scheduler that drains two FIFOs into one valid/ready sink.
// Each grant fetches up to MAX_BURST words, alternating FETCH (capture+pop) and SEND (hold).
module fifo_rd_arb #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                  r_clk,
    input  logic                  r_rst,
    input  logic                  drain_en,
    input  logic                  ch0_empty,
    input  logic [DATA_WIDTH-1:0] ch0_rd_data,
    output logic                  ch0_r_inc,
    input  logic                  ch1_empty,
    input  logic [DATA_WIDTH-1:0] ch1_rd_data,
    output logic                  ch1_r_inc,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_ch,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] SEND  = 2'd2;
    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  tx_ch_q, tx_ch_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  ch0_r_inc_q, ch0_r_inc_d;
    logic                  ch1_r_inc_q, ch1_r_inc_d;
    logic [3:0]            burst_cnt_q, burst_cnt_d;
    logic                  last_gnt_q, last_gnt_d;
    logic                  gnt_q, gnt_d;
    logic [3:0]            cnt_inc;
    logic                  gnt_empty;

    assign cnt_inc   = burst_cnt_q + 4'd1;
    assign gnt_empty = gnt_q ? ch1_empty : ch0_empty;

    // Pop strobes are registered so they are high during the FETCH cycle itself.
    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data_q;
        tx_ch_d     = tx_ch_q;
        tx_valid_d  = tx_valid_q;
        burst_cnt_d = burst_cnt_q;
        last_gnt_d  = last_gnt_q;
        gnt_d       = gnt_q;
        ch0_r_inc_d = 1'b0;
        ch1_r_inc_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (drain_en && !(ch0_empty && ch1_empty)) begin
                    gnt_d       = (!ch0_empty && !ch1_empty) ? ~last_gnt_q : ch0_empty;
                    state_d     = FETCH;
                    burst_cnt_d = 4'd0;
                    ch0_r_inc_d = ~gnt_d;
                    ch1_r_inc_d = gnt_d;
                end
            end
            FETCH: begin
                tx_data_d  = gnt_q ? ch1_rd_data : ch0_rd_data;
                tx_ch_d    = gnt_q;
                tx_valid_d = 1'b1;
                state_d    = SEND;
            end
            SEND: begin
                if (tx_valid_q && tx_ready) begin
                    tx_valid_d  = 1'b0;
                    burst_cnt_d = cnt_inc;
                    if (drain_en && !gnt_empty && cnt_inc < BURST_LIM) begin
                        state_d     = FETCH;
                        ch0_r_inc_d = ~gnt_q;
                        ch1_r_inc_d = gnt_q;
                    end else begin
                        last_gnt_d = gnt_q;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            state_q     <= IDLE;
            tx_data_q   <= '0;
            tx_ch_q     <= 1'b0;
            tx_valid_q  <= 1'b0;
            ch0_r_inc_q <= 1'b0;
            ch1_r_inc_q <= 1'b0;
            burst_cnt_q <= 4'd0;
            last_gnt_q  <= 1'b1;
            gnt_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_data_q   <= tx_data_d;
            tx_ch_q     <= tx_ch_d;
            tx_valid_q  <= tx_valid_d;
            ch0_r_inc_q <= ch0_r_inc_d;
            ch1_r_inc_q <= ch1_r_inc_d;
            burst_cnt_q <= burst_cnt_d;
            last_gnt_q  <= last_gnt_d;
            gnt_q       <= gnt_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_ch     = tx_ch_q;
    assign tx_valid  = tx_valid_q;
    assign ch0_r_inc = ch0_r_inc_q;
    assign ch1_r_inc = ch1_r_inc_q;
    assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_fifo_rd_arb.sv
// tb_fifo_rd_arb: directed bench with two behavioural FIFOs and a transfer logger.
module tb_fifo_rd_arb;
    logic       clk = 1'b0;
    logic       r_rst = 1'b1;
    logic       drain_en = 1'b1;
    logic       tx_ready = 1'b1;
    logic       ch0_empty, ch1_empty, ch0_r_inc, ch1_r_inc;
    logic [7:0] ch0_rd_data, ch1_rd_data, tx_data;
    logic       tx_ch, tx_valid, busy;

    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    logic [7:0] wp0 = '0, wp1 = '0, rp0 = '0, rp1 = '0;
    logic [7:0] xf_data [64];
    logic       xf_ch [64];
    int         xf_cyc [64];
    int         xf_n = 0, cyc = 0, inc0_n = 0, inc1_n = 0, viol_n = 0;
    int         total = 0, bad = 0;

    always #5 clk = ~clk;

    assign ch0_empty   = rp0 == wp0;
    assign ch1_empty   = rp1 == wp1;
    assign ch0_rd_data = mem0[rp0];
    assign ch1_rd_data = mem1[rp1];

    fifo_rd_arb #(.DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .r_clk(clk), .r_rst(r_rst), .drain_en(drain_en),
        .ch0_empty(ch0_empty), .ch0_rd_data(ch0_rd_data), .ch0_r_inc(ch0_r_inc),
        .ch1_empty(ch1_empty), .ch1_rd_data(ch1_rd_data), .ch1_r_inc(ch1_r_inc),
        .tx_data(tx_data), .tx_ch(tx_ch), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy)
    );

    // FIFO pop model, transfer log and protocol watch
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ch0_r_inc) begin rp0 <= rp0 + 8'd1; inc0_n <= inc0_n + 1; end
        if (ch1_r_inc) begin rp1 <= rp1 + 8'd1; inc1_n <= inc1_n + 1; end
        if ((ch0_r_inc && ch1_r_inc) || (ch0_r_inc && ch0_empty) || (ch1_r_inc && ch1_empty))
            viol_n <= viol_n + 1;
        if (!r_rst && tx_valid && tx_ready) begin
            xf_data[xf_n] <= tx_data;
            xf_ch[xf_n]   <= tx_ch;
            xf_cyc[xf_n]  <= cyc;
            xf_n          <= xf_n + 1;
        end
    end

    task automatic push0(input logic [7:0] d); mem0[wp0] = d; wp0 = wp0 + 8'd1; endtask
    task automatic push1(input logic [7:0] d); mem1[wp1] = d; wp1 = wp1 + 8'd1; endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [12:0] e(input logic i0, i1, v, c, b, input logic [7:0] d);
        return {i0, i1, v, c, b, d};
    endfunction

    typedef struct packed { logic rst; logic rdy; logic [12:0] exp; } cyc_row_t;
    typedef struct packed { logic ch; logic [7:0] d; logic [7:0] gap; } xf_row_t;

    cyc_row_t t1 [10];
    xf_row_t  t2 [12];
    int       bx, b0, b1;

    initial begin
        // {inc0, inc1, valid, ch, busy, data} after each edge
        t1[0] = {1'b1, 1'b1, e(0, 0, 0, 0, 0, 8'h00)};
        t1[1] = {1'b1, 1'b1, e(0, 0, 0, 0, 0, 8'h00)};
        t1[2] = {1'b0, 1'b1, e(1, 0, 0, 0, 1, 8'h00)};
        t1[3] = {1'b0, 1'b1, e(0, 0, 1, 0, 1, 8'hA1)};
        t1[4] = {1'b0, 1'b1, e(1, 0, 0, 0, 1, 8'hA1)};
        t1[5] = {1'b0, 1'b1, e(0, 0, 1, 0, 1, 8'hA2)};
        t1[6] = {1'b0, 1'b1, e(1, 0, 0, 0, 1, 8'hA2)};
        t1[7] = {1'b0, 1'b1, e(0, 0, 1, 0, 1, 8'hA3)};
        t1[8] = {1'b0, 1'b1, e(0, 0, 0, 0, 0, 8'hA3)};
        t1[9] = {1'b0, 1'b1, e(0, 0, 0, 0, 0, 8'hA3)};
        t2[0]  = {1'b0, 8'h10, 8'd0}; t2[1]  = {1'b0, 8'h11, 8'd2};
        t2[2]  = {1'b0, 8'h12, 8'd2}; t2[3]  = {1'b0, 8'h13, 8'd2};
        t2[4]  = {1'b1, 8'h20, 8'd3}; t2[5]  = {1'b1, 8'h21, 8'd2};
        t2[6]  = {1'b1, 8'h22, 8'd2}; t2[7]  = {1'b1, 8'h23, 8'd2};
        t2[8]  = {1'b0, 8'h14, 8'd3}; t2[9]  = {1'b0, 8'h15, 8'd2};
        t2[10] = {1'b1, 8'h24, 8'd3}; t2[11] = {1'b1, 8'h25, 8'd2};

        // reset with ch0 loaded, then a 3-word ch0-only burst, cycle by cycle
        push0(8'hA1); push0(8'hA2); push0(8'hA3);
        for (int i = 0; i < 10; i++) begin
            r_rst = t1[i].rst;
            tx_ready = t1[i].rdy;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("cycle%0d", i),
                {19'd0, ch0_r_inc, ch1_r_inc, tx_valid, tx_ch, busy, tx_data}, {19'd0, t1[i].exp});
        end

        // last_gnt is now 0, so ch1 wins the tie
        bx = xf_n;
        push0(8'hB0); push1(8'hC0);
        for (int i = 0; i < 40 && xf_n - bx < 2; i++) @(negedge clk);
        chk("tie_first", {xf_ch[bx], xf_data[bx]}, {1'b1, 8'hC0});
        chk("tie_second", {xf_ch[bx+1], xf_data[bx+1]}, {1'b0, 8'hB0});

        // fresh reset, 6 words each, bursts of 4
        r_rst = 1'b1;
        for (int i = 0; i < 6; i++) begin push0(8'h10 + 8'(i)); push1(8'h20 + 8'(i)); end
        @(negedge clk); @(negedge clk);
        r_rst = 1'b0;
        bx = xf_n;
        for (int i = 0; i < 200 && xf_n - bx < 12; i++) @(negedge clk);
        chk("rr_count", xf_n - bx, 12);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("rr_word%0d", i), {xf_ch[bx+i], xf_data[bx+i]}, {t2[i].ch, t2[i].d});
            if (i > 0) chk($sformatf("rr_gap%0d", i), xf_cyc[bx+i] - xf_cyc[bx+i-1], t2[i].gap);
        end

        // back-pressure: word held for 6 cycles
        tx_ready = 1'b0;
        push0(8'h5C);
        for (int i = 0; i < 20 && !tx_valid; i++) @(negedge clk);
        bx = xf_n; b0 = inc0_n; b1 = inc1_n;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("hold%0d", k), {ch0_r_inc, ch1_r_inc, tx_valid, tx_ch, tx_data},
                {1'b0, 1'b0, 1'b1, 1'b0, 8'h5C});
            if (k == 5) tx_ready = 1'b1;
            @(negedge clk);
        end
        chk("hold_drop", tx_valid, 0);
        repeat (4) @(negedge clk);
        chk("hold_xfers", xf_n - bx, 1);
        chk("hold_data", xf_data[bx], 8'h5C);
        chk("hold_pops", inc0_n + inc1_n - b0 - b1, 0);

        // drain_en dropped during 2nd SEND of a ch1 burst
        push1(8'h60); push1(8'h61); push1(8'h62); push1(8'h63); push1(8'h64);
        bx = xf_n; b1 = inc1_n;
        for (int i = 0; i < 30 && !(tx_valid && xf_n - bx == 1); i++) @(negedge clk);
        drain_en = 1'b0;
        repeat (10) @(negedge clk);
        chk("drain_pops", inc1_n - b1, 2);
        chk("drain_xfers", xf_n - bx, 2);
        chk("drain_last", {xf_ch[bx+1], xf_data[bx+1]}, {1'b1, 8'h61});
        chk("drain_idle", busy, 0);
        chk("drain_left", wp1 - rp1, 3);

        // reset during SEND discards the held word
        drain_en = 1'b1;
        for (int i = 0; i < 40 && !(ch1_empty && !busy); i++) @(negedge clk);
        tx_ready = 1'b0;
        push0(8'h3E); push0(8'h3F);
        for (int i = 0; i < 20 && !tx_valid; i++) @(negedge clk);
        chk("rst_held", {tx_valid, tx_data}, {1'b1, 8'h3E});
        r_rst = 1'b1;
        push1(8'h70);
        @(negedge clk);
        chk("rst_clear", {tx_valid, busy, ch0_r_inc, ch1_r_inc}, 0);
        @(negedge clk);
        r_rst = 1'b0;
        tx_ready = 1'b1;
        bx = xf_n;
        for (int i = 0; i < 30 && xf_n - bx < 2; i++) @(negedge clk);
        chk("rst_next0", {xf_ch[bx], xf_data[bx]}, {1'b0, 8'h3F});
        chk("rst_next1", {xf_ch[bx+1], xf_data[bx+1]}, {1'b1, 8'h70});

        chk("pop_rules", viol_n, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
